// File: rtl/alu_wb_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_wb_seq_pkg : widths, ALU type codes and FSM encodings for alu_wb_seq  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_wb_seq_pkg;

    localparam int DAT_W     = 128;
    localparam int ADDR_W    = 5;
    localparam int ALU_TYP_W = 4;

    localparam logic [3:0] ALU_TYP_SPLIT  = 4'd2;
    localparam logic [3:0] ALU_TYP_DIV    = 4'd5;
    localparam logic [3:0] ALU_TYP_RSHIFT = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_WR1  = 2'd2;
    localparam logic [1:0] ST_WR2  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_wb_seq.sv
// +--------------------------------------------------------------------------+
// | alu_wb_seq : captures ALU results and issues in-order GPRF write-backs    |
// | Optional forwarding outputs enabled by macro ALU_WB_FWD_EN                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_wb_seq
    import alu_wb_seq_pkg::*;
#(
    parameter int DAT_W     = alu_wb_seq_pkg::DAT_W,
    parameter int ADDR_W    = alu_wb_seq_pkg::ADDR_W,
    parameter int ALU_TYP_W = alu_wb_seq_pkg::ALU_TYP_W
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 t_cs,
    input  logic                 i_iss_valid,
    input  logic [ALU_TYP_W-1:0] i_iss_typ,
    input  logic [ADDR_W-1:0]    i_iss_rd1,
    input  logic [ADDR_W-1:0]    i_iss_rd2,
    input  logic                 i_iss_wb_en,
    input  logic                 i_alu_done,
    input  logic [DAT_W-1:0]     i_alu_dat,
    input  logic [DAT_W-1:0]     i_alu_dat2,
    output logic                 o_busy,
    output logic                 o_gprf_we,
    output logic [ADDR_W-1:0]    o_gprf_waddr,
    output logic [DAT_W-1:0]     o_gprf_wdat,
    output logic                 o_imem_done,
`ifdef ALU_WB_FWD_EN
    output logic                 o_fwd_valid,
    output logic [ADDR_W-1:0]    o_fwd_addr,
    output logic [DAT_W-1:0]     o_fwd_dat,
`endif
    output logic                 o_jmp_sel
);

    function automatic logic is_dual(input logic [ALU_TYP_W-1:0] typ);
        return (typ == ALU_TYP_W'(ALU_TYP_SPLIT)) ||
               (typ == ALU_TYP_W'(ALU_TYP_DIV))   ||
               (typ == ALU_TYP_W'(ALU_TYP_RSHIFT));
    endfunction

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [ALU_TYP_W-1:0] r_typ;
    logic [ADDR_W-1:0]    r_rd1;
    logic [ADDR_W-1:0]    r_rd2;
    logic                 r_wb_en;
    logic [DAT_W-1:0]     r_dat;
    logic [DAT_W-1:0]     r_dat2;
    logic                 r_jmp_sel;
    logic                 w_second_wr;

    assign w_second_wr = is_dual(r_typ) && r_wb_en;
    assign o_jmp_sel   = r_jmp_sel;

    // State and capture bank; t_cs low freezes everything, so Moore outputs hold too
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state   <= ST_IDLE;
            r_typ     <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_wb_en   <= 1'b0;
            r_dat     <= '0;
            r_dat2    <= '0;
            r_jmp_sel <= 1'b0;
        end else if (t_cs) begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && i_iss_valid) begin
                r_typ   <= i_iss_typ;
                r_rd1   <= i_iss_rd1;
                r_rd2   <= i_iss_rd2;
                r_wb_en <= i_iss_wb_en;
            end
            if (r_state == ST_WAIT && i_alu_done) begin
                r_dat     <= i_alu_dat;
                r_dat2    <= i_alu_dat2;
                r_jmp_sel <= i_alu_dat[DAT_W-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_iss_valid) w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_alu_done)  w_state_nxt = ST_WR1;
            ST_WR1:  w_state_nxt = w_second_wr ? ST_WR2 : ST_IDLE;
            ST_WR2:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = 1'b0;
        o_gprf_we    = 1'b0;
        o_gprf_waddr = '0;
        o_gprf_wdat  = '0;
        o_imem_done  = 1'b0;
        case (r_state)
            ST_WAIT: o_busy = 1'b1;
            ST_WR1: begin
                o_busy      = 1'b1;
                o_gprf_we   = r_wb_en;
                o_imem_done = !w_second_wr;
                if (r_wb_en) begin
                    o_gprf_waddr = r_rd1;
                    o_gprf_wdat  = r_dat;
                end
            end
            ST_WR2: begin
                o_busy       = 1'b1;
                o_gprf_we    = 1'b1;
                o_gprf_waddr = r_rd2;
                o_gprf_wdat  = r_dat2;
                o_imem_done  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ALU_WB_FWD_EN
    // Bypass copy of the latest write, invalidated once the next instruction is accepted
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            o_fwd_valid <= 1'b0;
            o_fwd_addr  <= '0;
            o_fwd_dat   <= '0;
        end else if (t_cs) begin
            if (r_state == ST_IDLE && i_iss_valid) begin
                o_fwd_valid <= 1'b0;
            end else if (o_gprf_we) begin
                o_fwd_valid <= 1'b1;
                o_fwd_addr  <= o_gprf_waddr;
                o_fwd_dat   <= o_gprf_wdat;
            end
        end
    end
`endif

endmodule

`default_nettype wire
